ex_stage: RTL

- Execute stage of the 5-stage RISC-V pipeline, placed between the ID block and the memory stage.
- Holds the ID/EX pipeline register (with flush/bubble) and applies forwarding muxes to the operands.
- Performs the ALU operation and resolves branch/jump, driving the next-PC select and target back to the IF block.
- Holds the EX/MEM pipeline register feeding the memory stage.

---
 rtl/ex_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register with bubble insertion, operand forwarding,
// ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_e,
  input  logic                  regwrite_d,
  input  logic                  memwrite_d,
  input  logic                  jump_d,
  input  logic                  branch_d,
  input  logic                  alusrc_d,
  input  logic [1:0]            resultsrc_d,
  input  logic [2:0]            alucontrol_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       extimm_d,
  input  logic [XLEN-1:0]       pcplus4_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [1:0]            forward_a_e,
  input  logic [1:0]            forward_b_e,
  input  logic [XLEN-1:0]       result_w,
  output logic [REG_ADDR_W-1:0] rs1_e,
  output logic [REG_ADDR_W-1:0] rs2_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [1:0]            resultsrc_e,
  output logic                  regwrite_e,
  output logic                  pcsrc_e,
  output logic [XLEN-1:0]       pctarget_e,
  output logic                  regwrite_m,
  output logic                  memwrite_m,
  output logic [1:0]            resultsrc_m,
  output logic [XLEN-1:0]       aluresult_m,
  output logic [XLEN-1:0]       writedata_m,
  output logic [XLEN-1:0]       pcplus4_m,
  output logic [REG_ADDR_W-1:0] rd_m
);

  // ID/EX state
  logic                  regwrite_e_reg, memwrite_e_reg, jump_e_reg, branch_e_reg, alusrc_e_reg;
  logic [1:0]            resultsrc_e_reg;
  logic [2:0]            alucontrol_e_reg;
  logic [XLEN-1:0]       rd1_e_reg, rd2_e_reg, pc_e_reg, extimm_e_reg, pcplus4_e_reg;
  logic [REG_ADDR_W-1:0] rs1_e_reg, rs2_e_reg, rd_e_reg;

  // EX/MEM state
  logic                  regwrite_m_reg, memwrite_m_reg;
  logic [1:0]            resultsrc_m_reg;
  logic [XLEN-1:0]       aluresult_m_reg, writedata_m_reg, pcplus4_m_reg;
  logic [REG_ADDR_W-1:0] rd_m_reg;

  // Execute-cycle combinational values
  logic [XLEN-1:0] srca, srcb, writedata_e, aluresult_e;
  logic            zero_e;

  // ID/EX capture; a flush loads an all-zero bubble, reset wins over flush
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      regwrite_e_reg   <= 1'b0;
      memwrite_e_reg   <= 1'b0;
      jump_e_reg       <= 1'b0;
      branch_e_reg     <= 1'b0;
      alusrc_e_reg     <= 1'b0;
      resultsrc_e_reg  <= '0;
      alucontrol_e_reg <= '0;
      rd1_e_reg        <= '0;
      rd2_e_reg        <= '0;
      pc_e_reg         <= '0;
      extimm_e_reg     <= '0;
      pcplus4_e_reg    <= '0;
      rs1_e_reg        <= '0;
      rs2_e_reg        <= '0;
      rd_e_reg         <= '0;
    end else begin
      regwrite_e_reg   <= regwrite_d;
      memwrite_e_reg   <= memwrite_d;
      jump_e_reg       <= jump_d;
      branch_e_reg     <= branch_d;
      alusrc_e_reg     <= alusrc_d;
      resultsrc_e_reg  <= resultsrc_d;
      alucontrol_e_reg <= alucontrol_d;
      rd1_e_reg        <= rd1_d;
      rd2_e_reg        <= rd2_d;
      pc_e_reg         <= pc_d;
      extimm_e_reg     <= extimm_d;
      pcplus4_e_reg    <= pcplus4_d;
      rs1_e_reg        <= rs1_d;
      rs2_e_reg        <= rs2_d;
      rd_e_reg         <= rd_d;
    end
  end

  // Forwarding muxes (11 falls back to the ID/EX value) and ALU
  always_comb begin
    case (forward_a_e)
      2'b01:   srca = result_w;
      2'b10:   srca = aluresult_m_reg;
      default: srca = rd1_e_reg;
    endcase
    case (forward_b_e)
      2'b01:   writedata_e = result_w;
      2'b10:   writedata_e = aluresult_m_reg;
      default: writedata_e = rd2_e_reg;
    endcase
    srcb = alusrc_e_reg ? extimm_e_reg : writedata_e;
    case (alucontrol_e_reg)
      3'b000:  aluresult_e = srca + srcb;
      3'b001:  aluresult_e = srca - srcb;
      3'b010:  aluresult_e = srca & srcb;
      3'b011:  aluresult_e = srca | srcb;
      3'b100:  aluresult_e = srca ^ srcb;
      3'b101:  aluresult_e = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      3'b110:  aluresult_e = srca << srcb[4:0];
      default: aluresult_e = srca >> srcb[4:0];
    endcase
  end

  assign zero_e     = (aluresult_e == '0);
  assign pcsrc_e    = jump_e_reg | (branch_e_reg & zero_e);
  assign pctarget_e = pc_e_reg + extimm_e_reg;

  // EX/MEM capture; a bubble naturally carries zero write enables
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_m_reg  <= 1'b0;
      memwrite_m_reg  <= 1'b0;
      resultsrc_m_reg <= '0;
      aluresult_m_reg <= '0;
      writedata_m_reg <= '0;
      pcplus4_m_reg   <= '0;
      rd_m_reg        <= '0;
    end else begin
      regwrite_m_reg  <= regwrite_e_reg;
      memwrite_m_reg  <= memwrite_e_reg;
      resultsrc_m_reg <= resultsrc_e_reg;
      aluresult_m_reg <= aluresult_e;
      writedata_m_reg <= writedata_e;
      pcplus4_m_reg   <= pcplus4_e_reg;
      rd_m_reg        <= rd_e_reg;
    end
  end

  assign rs1_e       = rs1_e_reg;
  assign rs2_e       = rs2_e_reg;
  assign rd_e        = rd_e_reg;
  assign resultsrc_e = resultsrc_e_reg;
  assign regwrite_e  = regwrite_e_reg;
  assign regwrite_m  = regwrite_m_reg;
  assign memwrite_m  = memwrite_m_reg;
  assign resultsrc_m = resultsrc_m_reg;
  assign aluresult_m = aluresult_m_reg;
  assign writedata_m = writedata_m_reg;
  assign pcplus4_m   = pcplus4_m_reg;
  assign rd_m        = rd_m_reg;

endmodule
